// File: rtl/pulse_path_delay.sv
// Transport-style delay path with separate rise/fall delays, pulse rejection,
// error windows for marginal pulses and cancelled-schedule detection.
module pulse_path_delay #(
  parameter int unsigned DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          din,
  input  logic [DW-1:0] t_rise,
  input  logic [DW-1:0] t_fall,
  input  logic [DW-1:0] t_reject,
  input  logic [DW-1:0] t_error,
  input  logic          ondetect,
  input  logic          showcancel,
  output logic          dout,
  output logic          err,
  output logic          rej_pulse,
  output logic          cancel_pulse,
  output logic          ovf
);

  localparam logic [DW-1:0] ONE_C = DW'(1);
  localparam logic [DW-1:0] W_MAX = '1;

  typedef enum logic [1:0] {S_IDLE, S_ONE, S_TWO} state_t;

  state_t        state;
  logic          din_q;
  logic          v1, x1, v2, chk2;
  logic [DW-1:0] cnt1, cnt2, wcnt;

  logic          edge_c, mat1_c, cancel_c;
  logic [DW-1:0] d_c;

  assign edge_c   = (din != din_q);
  assign mat1_c   = (cnt1 == ONE_C);
  assign cancel_c = (state == S_TWO) && !chk2 && (cnt2 <= cnt1);

  // Delay for the edge being presented now; zero means next cycle.
  always_comb begin
    d_c = din ? t_rise : t_fall;
    if (d_c == '0) d_c = ONE_C;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      din_q        <= 1'b0;
      v1           <= 1'b0;
      x1           <= 1'b0;
      v2           <= 1'b0;
      chk2         <= 1'b0;
      cnt1         <= '0;
      cnt2         <= '0;
      wcnt         <= '0;
      dout         <= 1'b0;
      err          <= 1'b0;
      rej_pulse    <= 1'b0;
      cancel_pulse <= 1'b0;
      ovf          <= 1'b0;
    end else begin
      din_q        <= din;
      rej_pulse    <= 1'b0;
      cancel_pulse <= 1'b0;
      if (wcnt != W_MAX) wcnt <= wcnt + ONE_C;

      case (state)
        S_IDLE: begin
          if (edge_c) begin
            v1    <= din;
            x1    <= 1'b0;
            cnt1  <= d_c;
            wcnt  <= ONE_C;
            state <= S_ONE;
          end
        end

        S_ONE: begin
          if (mat1_c) begin
            if (x1) begin
              err <= 1'b1;
            end else begin
              dout <= v1;
              err  <= 1'b0;
            end
            if (edge_c) begin
              v1   <= din;
              x1   <= 1'b0;
              cnt1 <= d_c;
              wcnt <= ONE_C;
            end else begin
              state <= S_IDLE;
            end
          end else begin
            cnt1 <= cnt1 - ONE_C;
            // wcnt holds the width of the pulse that this edge terminates
            if (edge_c) begin
              if (wcnt < t_reject) begin
                rej_pulse <= 1'b1;
                state     <= S_IDLE;
              end else begin
                if (wcnt < t_error) begin
                  x1 <= 1'b1;
                  if (ondetect) err <= 1'b1;
                end
                v2    <= din;
                cnt2  <= d_c;
                chk2  <= 1'b0;
                wcnt  <= ONE_C;
                state <= S_TWO;
              end
            end
          end
        end

        S_TWO: begin
          if (edge_c) ovf <= 1'b1;
          if (cancel_c && !showcancel) begin
            cancel_pulse <= 1'b1;
            state        <= S_IDLE;
          end else begin
            if (cancel_c) begin
              cancel_pulse <= 1'b1;
              chk2         <= 1'b1;
              x1           <= 1'b1;
              if (ondetect) err <= 1'b1;
            end
            // An overdue slot2 (cancelled but shown) floors at 1 and matures next
            if (mat1_c) begin
              if (x1 || cancel_c) begin
                err <= 1'b1;
              end else begin
                dout <= v1;
                err  <= 1'b0;
              end
              v1    <= v2;
              x1    <= 1'b0;
              cnt1  <= (cnt2 > ONE_C) ? (cnt2 - ONE_C) : ONE_C;
              state <= S_ONE;
            end else begin
              cnt1 <= cnt1 - ONE_C;
              if (cnt2 > ONE_C) cnt2 <= cnt2 - ONE_C;
            end
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pulse_path_delay.sv
// Randomized and directed bench for pulse_path_delay: an event-time reference
// model feeds a scoreboard queue consumed by an independent monitor.
module tb_pulse_path_delay;

  logic       clk;
  logic       rst_n;
  logic       din;
  logic [7:0] t_rise, t_fall, t_reject, t_error;
  logic       ondetect, showcancel;
  logic       dout, err, rej_pulse, cancel_pulse, ovf;

  pulse_path_delay #(.DW(8)) dut (
    .clk(clk), .rst_n(rst_n), .din(din),
    .t_rise(t_rise), .t_fall(t_fall), .t_reject(t_reject), .t_error(t_error),
    .ondetect(ondetect), .showcancel(showcancel),
    .dout(dout), .err(err), .rej_pulse(rej_pulse),
    .cancel_pulse(cancel_pulse), .ovf(ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: pending transitions kept as absolute maturity times.
  typedef struct {
    logic val;
    int   due;
    logic x;
  } ev_t;

  ev_t        evq[$];
  logic [4:0] exp_q[$];
  int         cyc     = 0;
  int         last_t  = 0;
  logic       m_din_q = 1'b0;
  logic       m_dout  = 1'b0;
  logic       m_err   = 1'b0;
  logic       m_ovf   = 1'b0;
  logic       m_chk   = 1'b0;

  task automatic mature_head();
    if (evq[0].x) m_err = 1'b1;
    else begin
      m_dout = evq[0].val;
      m_err  = 1'b0;
    end
    void'(evq.pop_front());
  endtask

  task automatic push_ev(input logic v);
    int dl;
    dl = v ? int'(t_rise) : int'(t_fall);
    if (dl == 0) dl = 1;
    evq.push_back('{val: v, due: cyc + dl, x: 1'b0});
    last_t = cyc;
  endtask

  task automatic model_step(input logic d, input logic r);
    logic rej, can, ed;
    int   w;
    rej = 1'b0;
    can = 1'b0;
    if (!r) begin
      evq.delete();
      m_din_q = 1'b0;
      m_dout  = 1'b0;
      m_err   = 1'b0;
      m_ovf   = 1'b0;
    end else begin
      ed = (d != m_din_q);
      if (evq.size() == 2) begin
        if (ed) m_ovf = 1'b1;
        if (!m_chk && evq[1].due <= evq[0].due) begin
          can = 1'b1;
          if (!showcancel) evq.delete();
          else begin
            evq[0].x = 1'b1;
            m_chk    = 1'b1;
            if (ondetect) m_err = 1'b1;
          end
        end
        if (evq.size() == 2 && evq[0].due <= cyc) mature_head();
      end else if (evq.size() == 1) begin
        if (evq[0].due <= cyc) begin
          mature_head();
          if (ed) push_ev(d);
        end else if (ed) begin
          w = cyc - last_t;
          if (w > 255) w = 255;
          if (w < int'(t_reject)) begin
            rej = 1'b1;
            evq.delete();
          end else begin
            if (w < int'(t_error)) begin
              evq[0].x = 1'b1;
              if (ondetect) m_err = 1'b1;
            end
            push_ev(d);
            m_chk = 1'b0;
          end
        end
      end else if (ed) begin
        push_ev(d);
      end
      m_din_q = d;
    end
    exp_q.push_back({m_dout, m_err, rej, can, m_ovf});
    cyc++;
  endtask

  // One clock: drive at negedge, predict, return shortly after the posedge.
  task automatic step(input logic d, input logic r);
    @(negedge clk);
    din   = d;
    rst_n = r;
    model_step(d, r);
    @(posedge clk);
    #3;
  endtask

  task automatic check(input string nm, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, got, exp, $time);
    end
  endtask

  task automatic do_reset(input logic d);
    repeat (2) step(d, 1'b0);
  endtask

  task automatic set_t(input int tr, input int tf, input int tj, input int te);
    t_rise   = 8'(tr);
    t_fall   = 8'(tf);
    t_reject = 8'(tj);
    t_error  = 8'(te);
  endtask

  // Monitor: compares every DUT cycle against the oldest prediction.
  initial begin
    logic [4:0] e;
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_chk++;
        if ({dout, err, rej_pulse, cancel_pulse, ovf} != e) begin
          n_fail++;
          $display("FAIL sb t=%0t {dout,err,rej,cancel,ovf} got %b expected %b",
                   $time, {dout, err, rej_pulse, cancel_pulse, ovf}, e);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int   seen;
    logic dv;
    rst_n = 1'b0; din = 1'b0; ondetect = 1'b0; showcancel = 1'b0;
    set_t(5, 3, 0, 0);

    // Reset state and basic rise/fall delays
    do_reset(1'b0);
    check("rst_outputs", int'({dout, err, rej_pulse, cancel_pulse, ovf}), 0);
    step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    for (int j = 1; j <= 9; j++) begin
      step(1'b1, 1'b1);
      if (j == 4) check("rise_early", int'(dout), 0);
      if (j == 5) check("rise_at_5", int'(dout), 1);
    end
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    check("fall_early", int'(dout), 1);
    step(1'b0, 1'b1);
    check("fall_at_3", int'(dout), 0);

    // din high across reset release is a rising edge
    do_reset(1'b1);
    step(1'b1, 1'b1);
    for (int j = 1; j <= 5; j++) begin
      step(1'b1, 1'b1);
      if (j == 4) check("rst_rise_early", int'(dout), 0);
      if (j == 5) check("rst_rise_at_5", int'(dout), 1);
    end

    // Narrow pulse is rejected
    set_t(10, 10, 4, 8);
    do_reset(1'b0);
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    step(1'b0, 1'b1);
    check("rej_strobe", int'(rej_pulse), 1);
    step(1'b0, 1'b1);
    check("rej_one_cycle", int'(rej_pulse), 0);
    seen = 0;
    repeat (15) begin
      step(1'b0, 1'b1);
      if (dout || err) seen++;
    end
    check("rej_quiet", seen, 0);

    // Marginal pulse in error window, both reporting modes
    for (int od = 1; od >= 0; od--) begin
      ondetect = 1'(od);
      do_reset(1'b0);
      step(1'b1, 1'b1);
      for (int j = 1; j <= 16; j++) begin
        step((j < 6) ? 1'b1 : 1'b0, 1'b1);
        if (j == 5)  check("errw_before", int'(err), 0);
        if (j == 6)  check("errw_detect", int'(err), od);
        if (j == 9)  check("errw_pre_mature", int'(err), od);
        if (j == 10) check("errw_mature", int'(err), 1);
        if (j == 15) check("errw_hold", int'({dout, err}), 1);
        if (j == 16) check("errw_clear", int'({dout, err}), 0);
      end
    end

    // Cancelled schedule, silent and shown
    set_t(10, 2, 0, 0);
    ondetect = 1'b1;
    for (int sc = 0; sc <= 1; sc++) begin
      showcancel = 1'(sc);
      do_reset(1'b0);
      step(1'b1, 1'b1);
      step(1'b1, 1'b1);
      step(1'b1, 1'b1);
      step(1'b0, 1'b1);
      check("cancel_pre", int'(cancel_pulse), 0);
      step(1'b0, 1'b1);
      check("cancel_strobe", int'(cancel_pulse), 1);
      check("cancel_err", int'(err), sc);
      seen = 0;
      repeat (12) begin
        step(1'b0, 1'b1);
        if (dout) seen++;
      end
      check("cancel_dout_low", seen, 0);
      check("cancel_err_final", int'(err), 0);
    end

    // Overflow on third edge, then reset while two events pending
    set_t(50, 50, 0, 0);
    showcancel = 1'b0;
    do_reset(1'b0);
    step(1'b1, 1'b1);
    step(1'b0, 1'b1);
    check("ovf_pre", int'(ovf), 0);
    step(1'b1, 1'b1);
    check("ovf_set", int'(ovf), 1);
    seen = 0;
    repeat (10) begin
      step(1'b1, 1'b1);
      if (!ovf) seen++;
    end
    check("ovf_sticky", seen, 0);
    step(1'b1, 1'b0);
    check("midrst_outputs", int'({dout, err, rej_pulse, cancel_pulse, ovf}), 0);
    seen = 0;
    repeat (60) begin
      step(1'b0, 1'b1);
      if (dout || err || ovf) seen++;
    end
    check("midrst_quiet", seen, 0);

    // Randomized traffic against the model
    dv = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (i % 64 == 0) begin
        set_t($urandom_range(0, 12), $urandom_range(0, 12),
              $urandom_range(0, 8), $urandom_range(0, 10));
        ondetect   = 1'($urandom_range(0, 1));
        showcancel = 1'($urandom_range(0, 1));
      end
      if ($urandom_range(0, 3) == 0) dv = ~dv;
      step(dv, ($urandom_range(0, 299) != 0) ? 1'b1 : 1'b0);
    end

    step(dv, 1'b1);
    check("sb_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
